// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the channel accumulator: FSM states, the accumulator
// width rule, and the signed saturate/wrap narrowing helper.
package cnn_acc_pkg;

    // Generic working width used by the narrowing helper; covers any practical ACC_WIDTH.
    localparam int NARROW_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Full-precision accumulator width: the sum of max_ch values of w bits plus a bias never overflows.
    function automatic int acc_width(input int w, input int max_ch);
        return w + $clog2(max_ch) + 1;
    endfunction

    // Clamp v to the signed out_w range when sat_en is set; otherwise pass v through so
    // the caller's truncation to out_w bits yields the wrapped value.
    function automatic void sat_narrow(
        input  logic signed [NARROW_W-1:0] v,
        input  int                         out_w,
        input  bit                         sat_en,
        output logic signed [NARROW_W-1:0] res,
        output logic                       sat
    );
        logic signed [NARROW_W-1:0] one;
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (out_w - 1)) - one;
        lo     = -hi - one;
        res    = v;
        sat    = 1'b0;
        if (sat_en) begin
            if (v > hi) begin
                res = hi;
                sat = 1'b1;
            end else if (v < lo) begin
                res = lo;
                sat = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/acc_narrow.sv
// Combinational narrowing of the full-precision group sum to the output width,
// either clamping (with a flag) or wrapping depending on SATURATE.
module acc_narrow
    import cnn_acc_pkg::*;
#(
    parameter int IN_W      = 41,
    parameter int OUT_WIDTH = 32,
    parameter int SATURATE  = 1
) (
    input  logic signed [IN_W-1:0]      i_value,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_sat
);

    logic signed [NARROW_W-1:0] w_wide;
    logic signed [NARROW_W-1:0] w_res;
    logic                       w_sat;
    logic                       w_unused_hi;

    assign w_wide = NARROW_W'(i_value);

    // Clamp or pass through in the wide domain; the low bits are taken below.
    always_comb begin
        w_res = '0;
        w_sat = 1'b0;
        sat_narrow(w_wide, OUT_WIDTH, (SATURATE != 0), w_res, w_sat);
    end

    assign o_data      = w_res[OUT_WIDTH-1:0];
    assign o_sat       = w_sat;
    assign w_unused_hi = ^w_res[NARROW_W-1:OUT_WIDTH];

endmodule

// File: rtl/channel_accumulator.sv
// Streaming per-pixel channel reducer: sums N signed partial products plus a bias
// per group and emits one narrowed result per group over a valid/ready output.
module channel_accumulator
    import cnn_acc_pkg::*;
#(
    parameter int MAX_CHANNELS = 256,
    parameter int WIDTH        = 32,
    parameter int OUT_WIDTH    = 32,
    parameter int SATURATE     = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [$clog2(MAX_CHANNELS+1)-1:0]       cfg_channels,
    input  logic signed [WIDTH-1:0]                 bias,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [WIDTH-1:0]                 in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [OUT_WIDTH-1:0]             out_data,
    output logic                                    out_sat
);

    localparam int             CW    = $clog2(MAX_CHANNELS + 1);
    localparam int             ACC_W = acc_width(WIDTH, MAX_CHANNELS);
    localparam logic [CW-1:0]  MAX_N = CW'(MAX_CHANNELS);
    localparam logic [CW-1:0]  ONE_N = CW'(1);

    acc_state_e                  r_state;
    acc_state_e                  w_state_nxt;
    logic [CW-1:0]               r_n;
    logic [CW-1:0]               r_cnt;
    logic [CW-1:0]               w_eff_n;
    logic [CW-1:0]               w_n_m1;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [ACC_W-1:0]     w_base;
    logic signed [ACC_W-1:0]     w_sum;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_last;
    logic                        r_out_valid;
    logic                        r_out_sat;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic signed [OUT_WIDTH-1:0] w_nar_data;
    logic                        w_nar_sat;

    // A beat is only taken when the output slot is free or draining this cycle,
    // so a last beat can always load its result without stalling.
    assign w_ready  = rst_n && !clear && (!r_out_valid || out_ready);
    assign in_ready = w_ready;
    assign w_accept = in_valid && w_ready;

    // Map the configured group size onto the supported range 1..MAX_CHANNELS.
    always_comb begin
        w_eff_n = cfg_channels;
        if (cfg_channels == '0) begin
            w_eff_n = ONE_N;
        end else if (cfg_channels > MAX_N) begin
            w_eff_n = MAX_N;
        end
    end

    assign w_n_m1 = r_n - ONE_N;

    // Identify the accepted beat that closes the current group.
    always_comb begin
        w_last = 1'b0;
        if (w_accept) begin
            if (r_state == IDLE) begin
                w_last = (w_eff_n == ONE_N);
            end else begin
                w_last = (r_cnt == w_n_m1);
            end
        end
    end

    // The first beat of a group starts from the bias instead of the running sum.
    assign w_base = (r_state == IDLE) ? ACC_W'(bias) : r_acc;
    assign w_sum  = w_base + ACC_W'(in_data);

    acc_narrow #(
        .IN_W      (ACC_W),
        .OUT_WIDTH (OUT_WIDTH),
        .SATURATE  (SATURATE)
    ) u_narrow (
        .i_value (w_sum),
        .o_data  (w_nar_data),
        .o_sat   (w_nar_sat)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: clear aborts, the last beat returns to IDLE, any other beat accumulates.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_last ? IDLE : ACCUM;
        end
    end

    // Running sum, beat counter and the group size latched on the first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_n   <= ONE_N;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_n <= w_eff_n;
            end
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= (r_state == IDLE) ? ONE_N : r_cnt + ONE_N;
            end
        end
    end

    // Output slot: load on the last beat (even while draining), otherwise empty on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_nar_data;
            r_out_sat   <= w_nar_sat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_channel_accumulator.sv
// Directed bench for channel_accumulator: a 32-bit saturating instance plus two
// 8-bit output instances (saturate and wrap) driven by the same stimulus.
module tb_channel_accumulator;

    localparam int MAXC = 10;
    localparam int CW   = $clog2(MAXC + 1);

    logic                 clk;
    logic                 rst_n;
    logic [CW-1:0]        cfg;
    logic signed [31:0]   bias;
    logic                 clr;
    logic                 iv;
    logic signed [31:0]   id;
    logic                 ordy;

    logic                 rdy_m, ov_m, sat_m;
    logic signed [31:0]   od_m;
    logic                 rdy_s, ov_s, sat_s;
    logic signed [7:0]    od_s;
    logic                 rdy_w, ov_w, sat_w;
    logic signed [7:0]    od_w;

    int errs   = 0;
    int checks = 0;

    channel_accumulator #(.MAX_CHANNELS(MAXC), .WIDTH(32), .OUT_WIDTH(32), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_channels(cfg), .bias(bias), .clear(clr),
        .in_valid(iv), .in_ready(rdy_m), .in_data(id),
        .out_valid(ov_m), .out_ready(ordy), .out_data(od_m), .out_sat(sat_m)
    );

    channel_accumulator #(.MAX_CHANNELS(MAXC), .WIDTH(32), .OUT_WIDTH(8), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_channels(cfg), .bias(bias), .clear(clr),
        .in_valid(iv), .in_ready(rdy_s), .in_data(id),
        .out_valid(ov_s), .out_ready(ordy), .out_data(od_s), .out_sat(sat_s)
    );

    channel_accumulator #(.MAX_CHANNELS(MAXC), .WIDTH(32), .OUT_WIDTH(8), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .cfg_channels(cfg), .bias(bias), .clear(clr),
        .in_valid(iv), .in_ready(rdy_w), .in_data(id),
        .out_valid(ov_w), .out_ready(ordy), .out_data(od_w), .out_sat(sat_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [31:0] d);
        iv = 1'b1;
        id = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        cfg   = CW'(4);
        bias  = 32'sd10;
        clr   = 1'b0;
        iv    = 1'b0;
        id    = '0;
        ordy  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", rdy_m, 0);
        chk("rst_out_valid", ov_m, 0);
        chk("rst_out_data", od_m, 0);
        chk("rst_out_sat", sat_m, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", rdy_m, 1);

        // Basic sum: bias 10 + 1+2+3+4
        send(1); send(2); send(3);
        chk("basic_no_early_valid", ov_m, 0);
        send(4);
        chk("basic_valid", ov_m, 1);
        chk("basic_data", od_m, 20);
        chk("basic_sat", sat_m, 0);
        idle();
        chk("basic_pulse_ends", ov_m, 0);

        // Odd N back-to-back
        cfg  = CW'(3);
        bias = 32'sd0;
        send(5); send(-2); send(7);
        chk("b2b_g1_valid", ov_m, 1);
        chk("b2b_g1_data", od_m, 10);
        chk("b2b_ready_a", rdy_m, 1);
        send(-1);
        chk("b2b_drained", ov_m, 0);
        chk("b2b_ready_b", rdy_m, 1);
        send(-1);
        chk("b2b_ready_c", rdy_m, 1);
        send(-1);
        chk("b2b_g2_valid", ov_m, 1);
        chk("b2b_g2_data", od_m, -3);
        idle();

        // Saturation vs wrap on 8-bit outputs
        cfg = CW'(2);
        send(100); send(100);
        chk("sat_data", od_s, 127);
        chk("sat_flag", sat_s, 1);
        chk("wrap_data", od_w, -56);
        chk("wrap_flag", sat_w, 0);
        chk("wide_data", od_m, 200);
        chk("wide_flag", sat_m, 0);
        idle();

        // Backpressure with N=1
        cfg  = CW'(1);
        ordy = 1'b0;
        send(9);
        chk("bp_valid", ov_m, 1);
        chk("bp_data", od_m, 9);
        iv = 1'b1;
        id = 32'sd11;
        #1;
        chk("bp_ready_low", rdy_m, 0);
        @(posedge clk);
        #1;
        chk("bp_hold_valid", ov_m, 1);
        chk("bp_hold_data", od_m, 9);
        ordy = 1'b1;
        #1;
        chk("bp_ready_high", rdy_m, 1);
        @(posedge clk);
        #1;
        chk("bp_swap_valid", ov_m, 1);
        chk("bp_swap_data", od_m, 11);
        ordy = 1'b0;
        iv   = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_hold2_data", od_m, 11);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain", ov_m, 0);

        // Clear aborts a partial group and blocks the simultaneous beat
        cfg  = CW'(4);
        bias = 32'sd0;
        send(7); send(7); send(7);
        clr = 1'b1;
        iv  = 1'b1;
        id  = 32'sd50;
        #1;
        chk("clr_ready_low", rdy_m, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_no_output", ov_m, 0);
        send(1); send(1); send(1);
        chk("clr_partial", ov_m, 0);
        send(1);
        chk("clr_new_data", od_m, 4);
        chk("clr_new_valid", ov_m, 1);
        idle();

        // Reset mid-group
        send(5); send(5);
        iv    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov_m, 0);
        chk("mid_rst_ready", rdy_m, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(2); send(3); send(4); send(5);
        chk("post_rst_data", od_m, 14);
        chk("post_rst_valid", ov_m, 1);
        idle();

        // cfg_channels = 0 behaves as N = 1
        cfg = '0;
        send(6);
        chk("n0_a_valid", ov_m, 1);
        chk("n0_a_data", od_m, 6);
        send(8);
        chk("n0_b_valid", ov_m, 1);
        chk("n0_b_data", od_m, 8);
        idle();

        // cfg_channels above MAX clamps to MAX
        cfg = CW'(MAXC + 5);
        for (int i = 0; i < MAXC; i++) begin
            send(1);
            if (i == MAXC - 2) chk("clamp_not_yet", ov_m, 0);
            if (i == MAXC - 1) begin
                chk("clamp_valid", ov_m, 1);
                chk("clamp_data", od_m, MAXC);
            end
        end
        idle();

        // Mid-group config and bias changes are ignored
        cfg  = CW'(3);
        bias = 32'sd0;
        send(2);
        cfg  = CW'(1);
        bias = 32'sd100;
        send(3);
        chk("midcfg_no_early", ov_m, 0);
        send(4);
        chk("midcfg_valid", ov_m, 1);
        chk("midcfg_data", od_m, 9);
        idle();
        chk("final_idle", ov_m, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
